matrix_transpose_unit: RTL and testbench



---
 rtl/matrix_transpose_unit.sv | 171 +++++++++++++++++
 tb/tb_matrix_transpose_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_transpose_unit.sv
// matrix_transpose_unit
// Multi-cycle transpose of a signed M_ROWS x N_COLS matrix into a registered
// N_COLS x M_ROWS result, driven by a start/busy/done handshake.
// The input is captured into a snapshot on the start edge, then one element
// per cycle is copied in row-major order of the source.
// Build option: define MTU_SINGLE_CYCLE_EN to write the whole result on the
// start edge (no snapshot, no element index); COPY then lasts a single cycle.
//
// Handshake timing with start sampled at edge k:
//   busy rises at edge k and falls at edge k + M*N (the last copy edge),
//   the FSM sits in DONE for one cycle, and done is high for exactly one
//   cycle starting at edge k + M*N + 1. With MTU_SINGLE_CYCLE_EN, busy is
//   high for one cycle and done rises at edge k + 2.

module matrix_transpose_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int M_ROWS     = 2,
    parameter int N_COLS     = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         op_start_transpose,
    input  logic signed [DATA_WIDTH-1:0] input_matrix [0:M_ROWS-1][0:N_COLS-1],
    output logic signed [DATA_WIDTH-1:0] output_matrix_transposed [0:N_COLS-1][0:M_ROWS-1],
    output logic                         op_busy_transpose,
    output logic                         op_done_transpose
);

    localparam int NUM_ELEM = M_ROWS * N_COLS;
    localparam int IDX_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COPY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   start_accept;

    logic signed [DATA_WIDTH-1:0] res_q [0:N_COLS-1][0:M_ROWS-1];
    logic signed [DATA_WIDTH-1:0] res_d [0:N_COLS-1][0:M_ROWS-1];

`ifndef MTU_SINGLE_CYCLE_EN
    logic signed [DATA_WIDTH-1:0] snap_q [0:M_ROWS-1][0:N_COLS-1];
    logic signed [DATA_WIDTH-1:0] snap_d [0:M_ROWS-1][0:N_COLS-1];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_elem;

    assign last_elem = (idx_q == IDX_W'(NUM_ELEM - 1));
`endif

    // A start is only honoured in IDLE; starts in COPY or DONE are dropped.
    assign start_accept = (state_q == ST_IDLE) && op_start_transpose;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (op_start_transpose) begin
                    state_d = ST_COPY;
                end
            end
            ST_COPY: begin
`ifdef MTU_SINGLE_CYCLE_EN
                state_d = ST_DONE;
`else
                if (last_elem) begin
                    state_d = ST_DONE;
                end
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: busy follows the COPY state, done is a one-cycle pulse
    // registered from the DONE state.
    always_comb begin
        busy_d = (state_d == ST_COPY);
        done_d = (state_q == ST_DONE);
    end

    // Handshake output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Datapath next-state: snapshot capture, element index and result writes
    always_comb begin
        res_d = res_q;
`ifdef MTU_SINGLE_CYCLE_EN
        // Without a snapshot the only way to honour "input as sampled at the
        // start edge" is to write the whole transpose on that edge.
        if (start_accept) begin
            for (int r = 0; r < M_ROWS; r++) begin
                for (int c = 0; c < N_COLS; c++) begin
                    res_d[c][r] = input_matrix[r][c];
                end
            end
        end
`else
        snap_d = snap_q;
        idx_d  = idx_q;
        if (start_accept) begin
            snap_d = input_matrix;
            idx_d  = '0;
        end else if (state_q == ST_COPY) begin
            if (!last_elem) begin
                idx_d = idx_q + IDX_W'(1);
            end
            for (int r = 0; r < M_ROWS; r++) begin
                for (int c = 0; c < N_COLS; c++) begin
                    if (idx_q == IDX_W'(r * N_COLS + c)) begin
                        res_d[c][r] = snap_q[r][c];
                    end
                end
            end
        end
`endif
    end

    // Datapath registers; reset clears any partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_COLS; c++) begin
                for (int r = 0; r < M_ROWS; r++) begin
                    res_q[c][r] <= '0;
                end
            end
`ifndef MTU_SINGLE_CYCLE_EN
            for (int r = 0; r < M_ROWS; r++) begin
                for (int c = 0; c < N_COLS; c++) begin
                    snap_q[r][c] <= '0;
                end
            end
            idx_q <= '0;
`endif
        end else begin
            res_q <= res_d;
`ifndef MTU_SINGLE_CYCLE_EN
            snap_q <= snap_d;
            idx_q  <= idx_d;
`endif
        end
    end

    assign output_matrix_transposed = res_q;
    assign op_busy_transpose        = busy_q;
    assign op_done_transpose        = done_q;

endmodule

// File: tb/tb_matrix_transpose_unit.sv
// Bench for matrix_transpose_unit with default parameters (2x3, 8-bit).
// The reference model is a plain transpose of the matrix as it stood at the
// start edge, plus the expected done timing (start edge + M*N + 1).

module tb_matrix_transpose_unit;

    localparam int DW  = 8;
    localparam int M   = 2;
    localparam int N   = 3;
    localparam int MN  = M * N;
    localparam int LAT = MN + 1;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic signed [DW-1:0] a [0:M-1][0:N-1];
    logic signed [DW-1:0] y [0:N-1][0:M-1];
    logic busy;
    logic done;

    int errors = 0;
    int checks = 0;
    int exp_t [0:N-1][0:M-1];

    always #5 clk = ~clk;

    matrix_transpose_unit #(
        .DATA_WIDTH(DW),
        .M_ROWS    (M),
        .N_COLS    (N)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .op_start_transpose      (start),
        .input_matrix            (a),
        .output_matrix_transposed(y),
        .op_busy_transpose       (busy),
        .op_done_transpose       (done)
    );

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int v00, input int v01, input int v02,
                         input int v10, input int v11, input int v12);
        a[0][0] = DW'(v00); a[0][1] = DW'(v01); a[0][2] = DW'(v02);
        a[1][0] = DW'(v10); a[1][1] = DW'(v11); a[1][2] = DW'(v12);
    endtask

    task automatic set_a_rand();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                a[r][c] = DW'($urandom);
    endtask

    // Reference: result[c][r] is the source element [r][c] at start time.
    task automatic model_capture();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                exp_t[c][r] = int'(a[r][c]);
    endtask

    task automatic check_result(input string tag);
        for (int c = 0; c < N; c++)
            for (int r = 0; r < M; r++)
                check($sformatf("%s_y[%0d][%0d]", tag, c, r), y[c][r], exp_t[c][r]);
    endtask

    task automatic check_zero(input string tag);
        for (int c = 0; c < N; c++)
            for (int r = 0; r < M; r++)
                check($sformatf("%s_y[%0d][%0d]", tag, c, r), y[c][r], 0);
    endtask

    // One operation: start pulse, optional input change after the start edge,
    // optional extra start pulse at a COPY cycle; checks latency, single
    // done pulse, busy low at done and the transposed result.
    task automatic do_op(input string tag, input bit change_mid, input int poke_at);
        int first;
        int pulses;
        model_capture();
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_busy_rise"}, busy, 1);
        if (change_mid) set_a(9, 9, 9, 9, 9, 9);
        first  = -1;
        pulses = 0;
        for (int i = 1; i <= LAT + 6; i++) begin
            start = (i == poke_at);
            step();
            if (done) begin
                pulses++;
                if (first < 0) begin
                    first = i;
                    check({tag, "_busy_at_done"}, busy, 0);
                    check_result(tag);
                end
            end
        end
        start = 1'b0;
        check({tag, "_done_latency"}, first, LAT);
        check({tag, "_done_pulses"}, pulses, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int d1;
        int d2;

        rst   = 1'b1;
        start = 1'b0;
        set_a(0, 0, 0, 0, 0, 0);
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check_zero("rst");
        #2 rst = 1'b0;
        step();

        // Basic transpose, then result must hold in IDLE
        set_a(1, 2, 3, 4, 5, 6);
        do_op("basic", 1'b0, 0);
        step(); step(); step();
        check_result("basic_hold");

        // Signed extremes, bit-exact
        set_a(-128, 127, -1, 0, -5, 64);
        do_op("signed", 1'b0, 0);

        // Input changed during COPY is ignored; next start picks up the 9s
        set_a(7, -8, 21, -33, 100, -100);
        do_op("snap", 1'b1, 0);
        do_op("snap9", 1'b0, 0);

        // Start pulse during COPY cycle 3 is ignored
        set_a(-3, 14, 15, -92, 65, 35);
        do_op("poke", 1'b0, 3);

        // Asynchronous reset in the middle of COPY clears the partial result
        set_a(11, 22, 33, 44, 55, 66);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check_zero("midrst");
        step();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < LAT + 5; i++) begin
            step();
            if (done) pulses++;
        end
        check("midrst_no_done", pulses, 0);
        check_zero("midrst_after");
        do_op("post_rst", 1'b0, 0);

        // Start held high: second operation starts at the first IDLE edge
        // after DONE, i.e. done pulses at +LAT and +2*LAT+1.
        set_a_rand();
        model_capture();
        start  = 1'b1;
        step();
        d1     = -1;
        d2     = -1;
        pulses = 0;
        for (int i = 1; i <= 2 * LAT + 6; i++) begin
            step();
            if (i == LAT + 1) start = 1'b0;
            if (done) begin
                pulses++;
                if (d1 < 0) begin
                    d1 = i;
                    check_result("held1");
                    set_a_rand();
                    model_capture();
                end else if (d2 < 0) begin
                    d2 = i;
                    check_result("held2");
                end
            end
        end
        start = 1'b0;
        check("held_d1", d1, LAT);
        check("held_d2", d2, 2 * LAT + 1);
        check("held_pulses", pulses, 2);

        // Random matrices against the transpose model
        for (int k = 0; k < 12; k++) begin
            set_a_rand();
            do_op($sformatf("rand%0d", k), ($urandom_range(0, 3) == 0), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
